pa_pmp_chk_sched: RTL
=====================

// Module: pa_pmp_chk_sched
// PURPOSE
//  Schedules IFU and LSU PMP check requests onto the single shared PMP compare/attribute
//  datapath (address compare + access-attribute arbitration). Grants one requester,
//  drives the datapath for one cycle, resolves the lowest-index hit, and returns a
//  one-cycle deny response. Sits between the IFU/LSU request ports and the PMP regs/compare logic.
// PARAMETERS
//  ADDR_WIDTH  32  width of checked physical address
//  REGION_NUM  8   number of PMP entries; fixed at 8, matching the compare datapath
//  STARVE_MAX  4   consecutive LSU grants allowed while IFU waits (fixed-priority mode only)
// PORTS
//  pmpclk               in   1   block clock
//  cpurst_b             in   1   asynchronous reset, active-low
//  ifu_pmp_req_vld      in   1   IFU check request; held until granted
//  ifu_pmp_req_addr     in   AW  IFU fetch address; stable while vld=1
//  ifu_pmp_req_mmode    in   1   1 = machine mode, 0 = user mode
//  pmp_ifu_req_rdy      out  1   IFU grant this cycle (combinational)
//  pmp_ifu_rsp_vld      out  1   IFU response pulse
//  pmp_ifu_rsp_deny     out  1   IFU access denied (valid with rsp_vld)
//  lsu_pmp_req_vld      in   1   LSU check request; held until granted
//  lsu_pmp_req_addr     in   AW  LSU access address
//  lsu_pmp_req_mmode    in   1   1 = machine mode, 0 = user mode
//  lsu_pmp_req_st       in   1   1 = store, 0 = load
//  pmp_lsu_req_rdy      out  1   LSU grant this cycle (combinational)
//  pmp_lsu_rsp_vld      out  1   LSU response pulse
//  pmp_lsu_rsp_deny     out  1   LSU access denied
//  pmp_rsp_region       out  4   [3]=no hit, [2:0]=hit entry index; valid with either rsp_vld
//  csr_pmp_cfg_upd      in   1   pmpcfg/pmpaddr write in progress; blocks grants and captures
//  sched_comp_addr      out  AW  address to compare datapath (registered)
//  sched_comp_mmode     out  1   machine-mode qualifier to datapath
//  sched_comp_umode     out  1   user-mode qualifier to datapath (!mmode while COMP, else 0)
//  sched_comp_is_st     out  1   store qualifier to datapath
//  sched_comp_is_ifu    out  1   1 = IFU access; selects IFU vs LSU deny vector
//  comp_sched_hit       in   8   per-entry address hit (combinational from sched_comp_*)
//  comp_sched_deny      in   8   per-entry deny for the selected source
//  comp_sched_nohit_deny in  1   deny when no entry hits
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; starve_cnt=0; rr_last=0. An in-flight check is dropped;
//    requester still holds vld and is re-granted after reset.
//  - FSM: IDLE, COMP, RESP.
//    IDLE: if any vld && !csr_pmp_cfg_upd -> grant (rdy=1 one cycle), latch addr/mode/st/src
//      into sched_comp_* -> COMP. Else stay.
//    COMP: if csr_pmp_cfg_upd=1, stay; do not capture. Else capture result -> RESP.
//    RESP: assert rsp_vld for the latched source for exactly one cycle. Same cycle, a new grant
//      may issue (same rules as IDLE) -> COMP; else -> IDLE.
//  - Latency: grant in cycle N -> rsp_vld in N+2 (no cfg_upd). Peak throughput: 1 check / 2 cycles.
//  - Result: deny = comp_sched_deny[i] for lowest i with comp_sched_hit[i]=1;
//    if hit==0, deny = comp_sched_nohit_deny and region = 4'b1000. All latched in COMP.
//  - sched_comp_* are 0 outside COMP.
//  - Arbitration (default): LSU has priority. starve_cnt increments on each LSU grant while
//    ifu_pmp_req_vld=1. When starve_cnt==STARVE_MAX and both request, IFU is granted and
//    starve_cnt clears. starve_cnt also clears on any IFU grant, and on an LSU grant with IFU idle.
//    starve_cnt saturates at STARVE_MAX.
//  - Simultaneous events: at most one rdy per cycle. cfg_upd asserted in the same cycle as a
//    pending request -> no grant. RESP + cfg_upd -> response still issued; no new grant.
//  - rdy is never asserted when vld=0.
// CONFIGURATION
//  PMP_SCHED_RR_EN defined: round-robin. On contention, grant the source not granted last
//    (rr_last flag, reset 0 = LSU preferred first). starve_cnt is removed and STARVE_MAX is unused.
//  Not defined: fixed LSU priority with the starvation counter described above.
// TESTING
//  1. LSU load, umode, hit[3] only, deny[3]=1 -> lsu rdy@N, rsp_vld@N+2, deny=1, region=4'b0011.
//  2. IFU mmode, hit=0, nohit_deny=0 -> ifu rsp_vld@N+2, deny=0, region=4'b1000.
//  3. hit=8'b0010_0100, deny=8'b0010_0000 -> deny=0 (entry 2 wins), region=4'b0010.
//  4. Both vld continuously, STARVE_MAX=4 -> grants L,L,L,L,I,L,L,L,L,I...;
//     with PMP_SCHED_RR_EN -> L,I,L,I...
//  5. cfg_upd high 3 cycles during COMP -> no capture; rsp_vld 3 cycles late, result from post-update inputs.
//  6. cpurst_b low in COMP -> all outputs 0, IDLE; after release, held request granted again, one rsp only.

Source files
------------

// File: rtl/pa_pmp_chk_sched.sv
// pa_pmp_chk_sched: arbitrates IFU/LSU PMP check requests onto the single shared
// PMP compare datapath, holds the selected access for one compare cycle, resolves
// the lowest-index hit and returns a one-cycle deny response to the requester.
// Build option: define PMP_SCHED_RR_EN for round-robin arbitration; otherwise LSU
// has fixed priority with an IFU starvation counter limited by STARVE_MAX.
module pa_pmp_chk_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int REGION_NUM = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                  pmpclk,
    input  logic                  cpurst_b,
    input  logic                  ifu_pmp_req_vld,
    input  logic [ADDR_WIDTH-1:0] ifu_pmp_req_addr,
    input  logic                  ifu_pmp_req_mmode,
    output logic                  pmp_ifu_req_rdy,
    output logic                  pmp_ifu_rsp_vld,
    output logic                  pmp_ifu_rsp_deny,
    input  logic                  lsu_pmp_req_vld,
    input  logic [ADDR_WIDTH-1:0] lsu_pmp_req_addr,
    input  logic                  lsu_pmp_req_mmode,
    input  logic                  lsu_pmp_req_st,
    output logic                  pmp_lsu_req_rdy,
    output logic                  pmp_lsu_rsp_vld,
    output logic                  pmp_lsu_rsp_deny,
    output logic [3:0]            pmp_rsp_region,
    input  logic                  csr_pmp_cfg_upd,
    output logic [ADDR_WIDTH-1:0] sched_comp_addr,
    output logic                  sched_comp_mmode,
    output logic                  sched_comp_umode,
    output logic                  sched_comp_is_st,
    output logic                  sched_comp_is_ifu,
    input  logic [REGION_NUM-1:0] comp_sched_hit,
    input  logic [REGION_NUM-1:0] comp_sched_deny,
    input  logic                  comp_sched_nohit_deny
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_grant_ok;
    logic                  w_ifu_gnt;
    logic                  w_lsu_gnt;
    logic                  w_any_gnt;
    logic                  w_capture;
    logic                  w_hit_deny;
    logic [3:0]            w_hit_region;
    logic [ADDR_WIDTH-1:0] r_comp_addr;
    logic                  r_comp_mmode;
    logic                  r_comp_umode;
    logic                  r_comp_is_st;
    logic                  r_comp_is_ifu;
    logic                  r_rsp_deny;
    logic                  r_rsp_ifu;
    logic [3:0]            r_rsp_region;

`ifdef PMP_SCHED_RR_EN
    // 1 = LSU was granted last, so IFU wins the next contention
    logic r_rr_last;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] r_starve_cnt;
`endif

    // Grants only issue from IDLE or RESP, never during a cfg update or while in reset
    assign w_grant_ok = ((r_state == ST_IDLE) || (r_state == ST_RESP)) &&
                        !csr_pmp_cfg_upd && cpurst_b;

    // Arbitration: single requester wins outright, contention resolved by policy
    always_comb begin
        w_ifu_gnt = 1'b0;
        w_lsu_gnt = 1'b0;
        if (w_grant_ok) begin
            if (ifu_pmp_req_vld && lsu_pmp_req_vld) begin
`ifdef PMP_SCHED_RR_EN
                w_ifu_gnt = r_rr_last;
                w_lsu_gnt = !r_rr_last;
`else
                w_ifu_gnt = (r_starve_cnt == STARVE_LIM);
                w_lsu_gnt = (r_starve_cnt != STARVE_LIM);
`endif
            end else begin
                w_ifu_gnt = ifu_pmp_req_vld;
                w_lsu_gnt = lsu_pmp_req_vld;
            end
        end
    end

    assign w_any_gnt       = w_ifu_gnt | w_lsu_gnt;
    assign pmp_ifu_req_rdy = w_ifu_gnt;
    assign pmp_lsu_req_rdy = w_lsu_gnt;
    assign w_capture       = (r_state == ST_COMP) && !csr_pmp_cfg_upd;

    // Next-state logic for the IDLE -> COMP -> RESP check pipeline
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_gnt) w_state_next = ST_COMP;
            ST_COMP: if (!csr_pmp_cfg_upd) w_state_next = ST_RESP;
            ST_RESP: w_state_next = w_any_gnt ? ST_COMP : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pmpclk or negedge cpurst_b) begin
        if (!cpurst_b) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    // Lowest-index hit wins; no hit falls back to the default deny with region[3] set
    always_comb begin
        w_hit_deny   = comp_sched_nohit_deny;
        w_hit_region = 4'b1000;
        for (int i = REGION_NUM - 1; i >= 0; i--) begin
            if (comp_sched_hit[i]) begin
                w_hit_deny   = comp_sched_deny[i];
                w_hit_region = {1'b0, 3'(i)};
            end
        end
    end

    // Datapath drive: loaded on grant, held through COMP stalls, zero otherwise
    always_ff @(posedge pmpclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_comp_addr   <= '0;
            r_comp_mmode  <= 1'b0;
            r_comp_umode  <= 1'b0;
            r_comp_is_st  <= 1'b0;
            r_comp_is_ifu <= 1'b0;
        end else if (w_any_gnt) begin
            r_comp_addr   <= w_ifu_gnt ? ifu_pmp_req_addr : lsu_pmp_req_addr;
            r_comp_mmode  <= w_ifu_gnt ? ifu_pmp_req_mmode : lsu_pmp_req_mmode;
            r_comp_umode  <= w_ifu_gnt ? !ifu_pmp_req_mmode : !lsu_pmp_req_mmode;
            r_comp_is_st  <= w_lsu_gnt & lsu_pmp_req_st;
            r_comp_is_ifu <= w_ifu_gnt;
        end else if (w_state_next != ST_COMP) begin
            r_comp_addr   <= '0;
            r_comp_mmode  <= 1'b0;
            r_comp_umode  <= 1'b0;
            r_comp_is_st  <= 1'b0;
            r_comp_is_ifu <= 1'b0;
        end
    end

    // Result capture at the end of an unstalled COMP cycle
    always_ff @(posedge pmpclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rsp_deny   <= 1'b0;
            r_rsp_ifu    <= 1'b0;
            r_rsp_region <= 4'd0;
        end else if (w_capture) begin
            r_rsp_deny   <= w_hit_deny;
            r_rsp_ifu    <= r_comp_is_ifu;
            r_rsp_region <= w_hit_region;
        end
    end

`ifdef PMP_SCHED_RR_EN
    // Remember which source won the last grant
    always_ff @(posedge pmpclk or negedge cpurst_b) begin
        if (!cpurst_b)      r_rr_last <= 1'b0;
        else if (w_any_gnt) r_rr_last <= w_lsu_gnt;
    end
`else
    // Count LSU grants that overtook a waiting IFU request, saturating at the limit
    always_ff @(posedge pmpclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_starve_cnt <= '0;
        end else if (w_ifu_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_lsu_gnt) begin
            if (!ifu_pmp_req_vld)                r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`endif

    assign sched_comp_addr   = r_comp_addr;
    assign sched_comp_mmode  = r_comp_mmode;
    assign sched_comp_umode  = r_comp_umode;
    assign sched_comp_is_st  = r_comp_is_st;
    assign sched_comp_is_ifu = r_comp_is_ifu;

    assign pmp_ifu_rsp_vld  = (r_state == ST_RESP) &&  r_rsp_ifu;
    assign pmp_lsu_rsp_vld  = (r_state == ST_RESP) && !r_rsp_ifu;
    assign pmp_ifu_rsp_deny = pmp_ifu_rsp_vld & r_rsp_deny;
    assign pmp_lsu_rsp_deny = pmp_lsu_rsp_vld & r_rsp_deny;
    assign pmp_rsp_region   = (r_state == ST_RESP) ? r_rsp_region : 4'd0;

endmodule
